// File: rtl/uart_tx_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo_pkg
//  Description : Shared encodings for the buffered UART transmitter
//                (parity modes and transmit FSM states).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_fifo_pkg;

    // Parity selection as presented on par_mode_i
    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_MARK = 2'b11
    } par_mode_e;

    // Transmit framing FSM
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_fifo_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_fifo_sync
//  Description : Single-clock FIFO with registered occupancy. Writes while
//                full and reads while empty are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
            else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
        end
    end

    // Count reaches DEPTH exactly when its MSB is set, so full is a plain flop bit
    assign full_o  = count_q[AW];
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Buffered UART transmitter. Words are queued in a small FIFO
//                and serialised LSB first with optional parity and one or
//                two stop bits, one bit per baud_ce_i strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          baud_ce_i,
    input  logic                          tx_valid_i,
    input  logic [DATA_W-1:0]             tx_data_i,
    input  logic [1:0]                    par_mode_i,
    input  logic                          stop2_i,
    output logic                          tx_ready_o,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level_o,
    output logic                          tx_busy_o,
    output logic                          txd_o
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    tx_state_e              state_q, state_d;
    logic [DATA_W-1:0]      sh_q, sh_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   par_en_q, par_en_d;
    logic                   par_bit_q, par_bit_d;
    logic                   stop2_q, stop2_d;
    logic                   txd_q, txd_d;

    logic                   load;
    logic                   par_bit_w;
    logic [DATA_W-1:0]      fifo_rd_data;
    logic                   fifo_full;
    logic                   fifo_empty;

    uart_fifo_sync #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (tx_valid_i),
        .data_i  (tx_data_i),
        .pop_i   (load),
        .data_o  (fifo_rd_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (tx_level_o)
    );

    assign tx_ready_o = !fifo_full;
    assign tx_busy_o  = (state_q != ST_IDLE) || !fifo_empty;
    assign txd_o      = txd_q;

    // Parity of the head word, captured together with the word at load time
    always_comb begin
        par_bit_w = 1'b0;
        case (par_mode_i)
            PAR_EVEN: par_bit_w = ^fifo_rd_data;
            PAR_ODD:  par_bit_w = ~^fifo_rd_data;
            PAR_MARK: par_bit_w = 1'b1;
            default:  par_bit_w = 1'b0;
        endcase
    end

    // Framing FSM: advances one bit per baud strobe; load pops and starts a frame
    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        txd_d      = txd_q;
        load       = 1'b0;

        if (baud_ce_i) begin
            case (state_q)
                ST_IDLE: begin
                    load = !fifo_empty;
                end
                ST_START: begin
                    txd_d   = sh_q[0];
                    sh_d    = {1'b0, sh_q[DATA_W-1:1]};
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (cnt_q != LAST_BIT) begin
                        cnt_d = cnt_q + 1'b1;
                        txd_d = sh_q[0];
                        sh_d  = {1'b0, sh_q[DATA_W-1:1]};
                    end else if (par_en_q) begin
                        txd_d   = par_bit_q;
                        state_d = ST_PARITY;
                    end else begin
                        txd_d      = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = ST_STOP;
                    end
                end
                ST_PARITY: begin
                    txd_d      = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = ST_STOP;
                end
                ST_STOP: begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    txd_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase

            // Frame settings are frozen here so later input changes wait for the next word
            if (load) begin
                sh_d      = fifo_rd_data;
                par_en_d  = (par_mode_i != PAR_NONE);
                par_bit_d = par_bit_w;
                stop2_d   = stop2_i;
                txd_d     = 1'b0;
                state_d   = ST_START;
            end
        end
    end

    // State and line registers; reset forces the line high immediately
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            sh_q       <= '0;
            cnt_q      <= '0;
            stop_cnt_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            txd_q      <= txd_d;
        end
    end

endmodule
`default_nettype wire
